// File: rtl/ex_pkg.sv
// Shared types for the execute result stage:
// op slot indices, the EX/MEM result bundle and skid-buffer state.
package ex_pkg;

    localparam int XLEN    = 32;
    localparam int NUM_OPS = 13;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_XOR  = 4'd2,
        OP_OR   = 4'd3,
        OP_AND  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_EQ   = 4'd10,
        OP_GE   = 4'd11,
        OP_GEU  = 4'd12
    } op_idx_e;

    typedef struct packed {
        logic [XLEN-1:0] rslt;
        logic [4:0]      rd;
        logic            wb_en;
        logic            br_taken;
        logic [XLEN-1:0] br_target;
        logic            err;
    } ex_result_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    function automatic logic is_onehot(input logic [NUM_OPS-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < NUM_OPS; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return cnt == 1;
    endfunction

endpackage

// File: rtl/ex_skid_buf.sv
// Two-entry skid buffer; ready comes straight from the state register
// so downstream back-pressure never reaches upstream combinationally.
module ex_skid_buf
    import ex_pkg::*;
#(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    buf_state_e state_q, state_d;
    T           main_q, main_d;
    T           skid_q, skid_d;
    logic       accept;
    logic       pop;

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // skid is always the younger entry
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/ex_result_stage.sv
// Merges gated op-unit results, resolves branches and registers the
// bundle into the EX/MEM boundary through a two-entry skid buffer.
module ex_result_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_OPS = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_OPS-1:0]      op_sel,
    input  logic [NUM_OPS*XLEN-1:0] op_res,
    input  logic                    is_branch,
    input  logic                    br_inv,
    input  logic [XLEN-1:0]         pc,
    input  logic [XLEN-1:0]         br_off,
    input  logic [4:0]              rd,
    input  logic                    wb_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_rslt,
    output logic [4:0]              out_rd,
    output logic                    out_wb_en,
    output logic                    out_br_taken,
    output logic [XLEN-1:0]         out_br_target,
    output logic                    out_err
);

    import ex_pkg::*;

    logic [XLEN-1:0] merged;
    logic            err;
    ex_result_t      ent;
    ex_result_t      out_ent;

    always_comb begin
        // unselected units drive zero, so OR is a mux
        merged = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            merged = merged | op_res[k*XLEN +: XLEN];
        end
        err           = ~is_onehot(op_sel);
        ent           = '0;
        ent.rslt      = err ? '0 : merged;
        ent.rd        = rd;
        ent.wb_en     = wb_en & ~is_branch & ~err & (rd != 5'd0);
        ent.br_taken  = is_branch & (merged[0] ^ br_inv) & ~err;
        ent.br_target = pc + br_off;
        ent.err       = err;
    end

    ex_skid_buf #(
        .T (ex_result_t)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (ent),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_ent)
    );

    assign out_rslt      = out_ent.rslt;
    assign out_rd        = out_ent.rd;
    assign out_wb_en     = out_ent.wb_en;
    assign out_br_taken  = out_ent.br_taken;
    assign out_br_target = out_ent.br_target;
    assign out_err       = out_ent.err;

endmodule
